pkt_proc: RTL and testbench

// - Packet FIFO with an internal memory and a write-side FSM. Sits between an ingress packet source
//   (enqueue side) and an egress consumer (dequeue side).
// - Stores 32-bit words tagged with SOP/EOP, plus status flags and a fill level.
// - Admits or drops whole packets based on their declared length.

---
 rtl/pkt_proc_pkg.sv | 20 ++
 rtl/pkt_proc_mem.sv | 44 ++++
 rtl/pkt_proc.sv | 204 ++++++++++++++++++++
 tb/tb_pkt_proc.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_proc_pkg.sv
// Shared types and sizing for the packet FIFO.
//   DEPTH/ADDR_W : storage depth in words and its log2
//   DATA_W       : payload width
//   LEN_W        : width of the declared packet length
//   wr_state_t   : write-side FSM state
//   mem_word_t   : one stored word with its packet framing tags
package pkt_proc_pkg;
  localparam int DEPTH  = 16384;
  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 12;

  typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} wr_state_t;

  typedef struct packed {
    logic              sop;
    logic              eop;
    logic [DATA_W-1:0] data;
  } mem_word_t;
endpackage

// File: rtl/pkt_proc_mem.sv
// Simple dual-port synchronous RAM, DEPTH x 34 bits, one-cycle read latency.
// The read register only updates on a read, so the last word read stays on
// rdata until the next read.
//   clk, rst   : clock, async active-high reset (clears the read register)
//   clr        : synchronous clear of the read register
//   we/waddr/wdata : write port
//   re/raddr       : read port
//   rdata          : registered read data
module pkt_proc_mem #(
  parameter int DEPTH  = pkt_proc_pkg::DEPTH,
  parameter int ADDR_W = pkt_proc_pkg::ADDR_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    we,
  input  logic [ADDR_W-1:0]       waddr,
  input  pkt_proc_pkg::mem_word_t wdata,
  input  logic                    re,
  input  logic [ADDR_W-1:0]       raddr,
  output pkt_proc_pkg::mem_word_t rdata
);
  import pkt_proc_pkg::*;

  mem_word_t mem_q [DEPTH];
  mem_word_t rdata_q, rdata_d;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (clr)     rdata_d = '0;
    else if (re) rdata_d = mem_q[raddr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/pkt_proc.sv
// Packet FIFO with admission control on the write side.
// A packet is admitted at its SOP only if its declared length is non-zero and
// fits in the free space; otherwise the whole packet is dropped (packet_drop).
// The reader sees either the raw write pointer (cut-through) or the commit
// pointer, which only moves when a packet's last word is written.
//   clk / rstn (async, active-high) / sw_rstn (sync, active-low)
//   enqueue : enq_req, in_sop, in_eop, wr_data_i, pck_len_valid, pck_len_i
//   dequeue : deq_req -> rd_data_o, out_sop, out_eop (1 cycle later, held)
//   status  : full/empty/almost_*, overflow/underflow/drop pulses, wr_lvl
module pkt_proc #(
  parameter int DEPTH  = pkt_proc_pkg::DEPTH,
  parameter int ADDR_W = pkt_proc_pkg::ADDR_W
) (
  input  logic                            pck_proc_int_mem_fsm_clk,
  input  logic                            pck_proc_int_mem_fsm_rstn,
  input  logic                            pck_proc_int_mem_fsm_sw_rstn,
  input  logic                            empty_de_assert,
  input  logic                            enq_req,
  input  logic                            in_sop,
  input  logic                            in_eop,
  input  logic [pkt_proc_pkg::DATA_W-1:0] wr_data_i,
  input  logic                            pck_len_valid,
  input  logic [pkt_proc_pkg::LEN_W-1:0]  pck_len_i,
  input  logic                            deq_req,
  input  logic [4:0]                      pck_proc_almost_full_value,
  input  logic [4:0]                      pck_proc_almost_empty_value,
  output logic                            out_sop,
  output logic                            out_eop,
  output logic [pkt_proc_pkg::DATA_W-1:0] rd_data_o,
  output logic                            pck_proc_full,
  output logic                            pck_proc_empty,
  output logic                            pck_proc_almost_full,
  output logic                            pck_proc_almost_empty,
  output logic                            pck_proc_overflow,
  output logic                            pck_proc_underflow,
  output logic                            packet_drop,
  output logic [ADDR_W:0]                 pck_proc_wr_lvl
);
  import pkt_proc_pkg::*;

  localparam int PTR_W = ADDR_W + 1;
  localparam logic [PTR_W-1:0] DEPTH_L = PTR_W'(DEPTH);

  logic clk, rst;
  assign clk = pck_proc_int_mem_fsm_clk;
  assign rst = pck_proc_int_mem_fsm_rstn;

  wr_state_t        state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LEN_W-1:0] cnt_q, cnt_d, len_q, len_d, cnt_inc;
  logic full_q, full_d, empty_q, empty_d, afull_q, afull_d, aempty_q, aempty_d;
  logic ovf_q, ovf_d, udf_q, udf_d, drop_q, drop_d;

  logic [PTR_W-1:0] lvl, vis_lvl, space, lvl_nxt, vis_nxt;
  logic             full_now, admit, is_last, we, re;
  mem_word_t        wword, rword;

  // Current raw and reader-visible levels; both wrap naturally at PTR_W bits.
  assign lvl      = wr_ptr_q - rd_ptr_q;
  assign vis_lvl  = (empty_de_assert ? wr_ptr_q : commit_ptr_q) - rd_ptr_q;
  assign space    = DEPTH_L - lvl;
  assign full_now = (lvl == DEPTH_L);
  assign cnt_inc  = cnt_q + LEN_W'(1);
  assign admit    = pck_len_valid && (pck_len_i != '0) && (PTR_W'(pck_len_i) <= space);

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    is_last      = 1'b0;
    we           = 1'b0;
    re           = 1'b0;
    wword        = '0;
    ovf_d        = enq_req && full_now;
    udf_d        = deq_req && (vis_lvl == '0);
    drop_d       = 1'b0;

    if (deq_req && (vis_lvl != '0)) begin
      re       = 1'b1;
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    // A full FIFO reports overflow only; the word is discarded in either state.
    if (enq_req && !full_now) begin
      unique case (state_q)
        IDLE: begin
          if (in_sop) begin
            if (admit) begin
              is_last    = in_eop || (pck_len_i == LEN_W'(1));
              we         = 1'b1;
              wword.sop  = 1'b1;
              wword.eop  = is_last;
              wword.data = wr_data_i;
              wr_ptr_d   = wr_ptr_q + PTR_W'(1);
              cnt_d      = LEN_W'(1);
              len_d      = pck_len_i;
              // A single-word packet is complete on its SOP cycle.
              if (is_last) commit_ptr_d = wr_ptr_q + PTR_W'(1);
              else         state_d      = WRITE;
            end else begin
              drop_d = 1'b1;
            end
          end
        end
        WRITE: begin
          is_last    = in_eop || (cnt_inc == len_q);
          we         = 1'b1;
          wword.eop  = is_last;
          wword.data = wr_data_i;
          wr_ptr_d   = wr_ptr_q + PTR_W'(1);
          cnt_d      = cnt_inc;
          if (is_last) begin
            state_d      = IDLE;
            commit_ptr_d = wr_ptr_q + PTR_W'(1);
          end
        end
      endcase
    end

    lvl_nxt  = wr_ptr_d - rd_ptr_d;
    vis_nxt  = (empty_de_assert ? wr_ptr_d : commit_ptr_d) - rd_ptr_d;
    full_d   = (lvl_nxt == DEPTH_L);
    empty_d  = (vis_nxt == '0);
    afull_d  = (lvl_nxt >= (DEPTH_L - PTR_W'(pck_proc_almost_full_value)));
    aempty_d = (lvl_nxt <= PTR_W'(pck_proc_almost_empty_value));

    if (!pck_proc_int_mem_fsm_sw_rstn) begin
      state_d      = IDLE;
      wr_ptr_d     = '0;
      commit_ptr_d = '0;
      rd_ptr_d     = '0;
      cnt_d        = '0;
      len_d        = '0;
      we           = 1'b0;
      re           = 1'b0;
      full_d       = 1'b0;
      empty_d      = 1'b1;
      afull_d      = 1'b0;
      aempty_d     = 1'b1;
      ovf_d        = 1'b0;
      udf_d        = 1'b0;
      drop_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      len_q        <= '0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      afull_q      <= 1'b0;
      aempty_q     <= 1'b1;
      ovf_q        <= 1'b0;
      udf_q        <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      full_q       <= full_d;
      empty_q      <= empty_d;
      afull_q      <= afull_d;
      aempty_q     <= aempty_d;
      ovf_q        <= ovf_d;
      udf_q        <= udf_d;
      drop_q       <= drop_d;
    end
  end

  pkt_proc_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
    .clk   (clk),
    .rst   (rst),
    .clr   (!pck_proc_int_mem_fsm_sw_rstn),
    .we    (we),
    .waddr (wr_ptr_q[ADDR_W-1:0]),
    .wdata (wword),
    .re    (re),
    .raddr (rd_ptr_q[ADDR_W-1:0]),
    .rdata (rword)
  );

  assign out_sop               = rword.sop;
  assign out_eop               = rword.eop;
  assign rd_data_o             = rword.data;
  assign pck_proc_full         = full_q;
  assign pck_proc_empty        = empty_q;
  assign pck_proc_almost_full  = afull_q;
  assign pck_proc_almost_empty = aempty_q;
  assign pck_proc_overflow     = ovf_q;
  assign pck_proc_underflow    = udf_q;
  assign packet_drop           = drop_q;
  assign pck_proc_wr_lvl       = lvl;
endmodule

// File: tb/tb_pkt_proc.sv
// Self-checking bench for pkt_proc: directed scenarios plus randomized traffic
// checked against a queue-based packet model.
module tb_pkt_proc;
  localparam int DEPTH = 16384;

  logic        clk = 1'b0, rst = 1'b0, sw_rstn = 1'b1, ead = 1'b0;
  logic        enq = 1'b0, sop = 1'b0, eop = 1'b0, lenv = 1'b0, deq = 1'b0;
  logic [31:0] wdata = '0;
  logic [11:0] len = '0;
  logic [4:0]  afv = 5'd2, aev = 5'd3;
  logic        o_sop, o_eop, full, empty, afull, aempty, ovf, udf, drop;
  logic [31:0] rdata;
  logic [14:0] lvl;

  int n_vec = 0, n_err = 0;

  pkt_proc dut (
    .pck_proc_int_mem_fsm_clk(clk), .pck_proc_int_mem_fsm_rstn(rst),
    .pck_proc_int_mem_fsm_sw_rstn(sw_rstn), .empty_de_assert(ead),
    .enq_req(enq), .in_sop(sop), .in_eop(eop), .wr_data_i(wdata),
    .pck_len_valid(lenv), .pck_len_i(len), .deq_req(deq),
    .pck_proc_almost_full_value(afv), .pck_proc_almost_empty_value(aev),
    .out_sop(o_sop), .out_eop(o_eop), .rd_data_o(rdata),
    .pck_proc_full(full), .pck_proc_empty(empty),
    .pck_proc_almost_full(afull), .pck_proc_almost_empty(aempty),
    .pck_proc_overflow(ovf), .pck_proc_underflow(udf),
    .packet_drop(drop), .pck_proc_wr_lvl(lvl));

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  // Stored words in FIFO order; 'uncomm' is how many trailing words belong to
  // the packet still being written (invisible in store-and-forward mode).
  logic [33:0] mq[$];
  int          uncomm, plen, pcnt;
  bit          in_pkt, e_ovf, e_udf, e_drop;
  logic [33:0] e_rd;

  task automatic model_reset();
    mq.delete(); uncomm = 0; in_pkt = 0; plen = 0; pcnt = 0;
    e_rd = '0; e_ovf = 0; e_udf = 0; e_drop = 0;
  endtask

  function automatic int vis();
    return ead ? mq.size() : mq.size() - uncomm;
  endfunction

  task automatic model_step();
    int sz, v;
    bit last;
    if (!sw_rstn) begin model_reset(); return; end
    sz = mq.size(); v = vis();
    e_ovf = enq && (sz == DEPTH);
    e_udf = deq && (v == 0);
    e_drop = 0;
    if (deq && v > 0) e_rd = mq.pop_front();
    if (enq && sz < DEPTH) begin
      if (!in_pkt) begin
        if (sop) begin
          if (lenv && len != 0 && int'(len) <= DEPTH - sz) begin
            last = eop || (len == 1);
            mq.push_back({1'b1, last, wdata});
            if (!last) begin in_pkt = 1; uncomm = 1; plen = int'(len); pcnt = 1; end
          end else e_drop = 1;
        end
      end else begin
        pcnt++;
        last = eop || (pcnt == plen);
        mq.push_back({1'b0, last, wdata});
        if (last) begin in_pkt = 0; uncomm = 0; end else uncomm++;
      end
    end
  endtask

  function automatic logic [55:0] exp_bus();
    int sz, v;
    sz = mq.size(); v = vis();
    return {e_rd, sz == DEPTH, v == 0, sz >= DEPTH - int'(afv), sz <= int'(aev),
            e_ovf, e_udf, e_drop, 15'(sz)};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    model_step();
    @(posedge clk); #1;
  endtask

  task automatic idle_in();
    enq = 0; sop = 0; eop = 0; lenv = 0; len = '0; deq = 0;
  endtask

  task automatic put(input bit s, input bit e, input bit lv, input int ln, input logic [31:0] d);
    enq = 1; sop = s; eop = e; lenv = lv; len = ln[11:0]; wdata = d;
    cyc();
  endtask

  task automatic hard_reset();
    idle_in(); sw_rstn = 1;
    rst = 1; #2; rst = 0;
    model_reset();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #1 rst = 1; #2;
    n_vec++; if ({lvl, empty, aempty} !== {15'd0, 2'b11}) begin n_err++; $display("FAIL reset_flags got lvl=%0d empty=%b ae=%b exp 0 1 1", lvl, empty, aempty); end
    rst = 0; model_reset();
    put(1, 0, 1, 8, 32'h1111_0000); put(0, 0, 0, 0, 32'h1111_0001); put(0, 0, 0, 0, 32'h1111_0002);
    idle_in();
    n_vec++; if (lvl !== 15'd3) begin n_err++; $display("FAIL reset_prefill_lvl got %0d exp 3", lvl); end
    rst = 1; #2;
    n_vec++; if ({lvl, empty, aempty} !== {15'd0, 2'b11}) begin n_err++; $display("FAIL reset_mid_flags got lvl=%0d empty=%b ae=%b exp 0 1 1", lvl, empty, aempty); end
    n_vec++; if ({o_sop, o_eop, rdata, full, afull, ovf, udf, drop} !== '0) begin n_err++; $display("FAIL reset_mid_outs got nonzero outputs rdata=%h", rdata); end
    rst = 0; model_reset();
  endtask

  task automatic test_sf_packet();
    logic [31:0] d[4];
    ead = 0; afv = 5'd2; aev = 5'd3;
    for (int i = 0; i < 4; i++) begin
      d[i] = $urandom;
      put(i == 0, 0, i == 0, 4, d[i]);
      n_vec++; if (lvl !== 15'(i + 1)) begin n_err++; $display("FAIL sf_lvl%0d got %0d exp %0d", i, lvl, i + 1); end
      n_vec++; if (empty !== (i != 3)) begin n_err++; $display("FAIL sf_empty%0d got %b exp %b", i, empty, i != 3); end
      n_vec++; if (aempty !== (i + 1 <= 3)) begin n_err++; $display("FAIL sf_aempty%0d got %b exp %b", i, aempty, i + 1 <= 3); end
    end
    idle_in();
    for (int i = 0; i < 4; i++) begin
      deq = 1; cyc(); deq = 0;
      n_vec++; if ({o_sop, o_eop, rdata} !== {i == 0, i == 3, d[i]}) begin n_err++; $display("FAIL sf_read%0d got %b%b %h exp %b%b %h", i, o_sop, o_eop, rdata, i == 0, i == 3, d[i]); end
    end
    n_vec++; if ({lvl, empty} !== {15'd0, 1'b1}) begin n_err++; $display("FAIL sf_drained got lvl=%0d empty=%b exp 0 1", lvl, empty); end
  endtask

  task automatic test_underflow();
    logic [31:0] held;
    held = rdata;
    deq = 1; cyc(); deq = 0;
    n_vec++; if (udf !== 1'b1) begin n_err++; $display("FAIL underflow_pulse got %b exp 1", udf); end
    n_vec++; if (rdata !== held) begin n_err++; $display("FAIL underflow_data got %h exp %h", rdata, held); end
    cyc();
    n_vec++; if (udf !== 1'b0) begin n_err++; $display("FAIL underflow_clear got %b exp 0", udf); end
  endtask

  task automatic test_drops();
    for (int k = 0; k < 2; k++) begin
      put(1, 0, k == 1, (k == 0) ? 4 : 0, $urandom); idle_in();
      n_vec++; if (drop !== 1'b1) begin n_err++; $display("FAIL drop%0d_pulse got %b exp 1", k, drop); end
      put(0, 0, 0, 0, $urandom); idle_in();   // trailing body word must be ignored
      n_vec++; if ({drop, lvl} !== {1'b0, 15'd0}) begin n_err++; $display("FAIL drop%0d_after got drop=%b lvl=%0d exp 0 0", k, drop, lvl); end
    end
  endtask

  task automatic test_cut_through();
    logic [31:0] d[3];
    hard_reset(); ead = 1;
    foreach (d[i]) d[i] = $urandom;
    put(1, 0, 1, 3, d[0]); idle_in();
    n_vec++; if ({empty, lvl} !== {1'b0, 15'd1}) begin n_err++; $display("FAIL ct_sop got empty=%b lvl=%0d exp 0 1", empty, lvl); end
    deq = 1; put(0, 0, 0, 0, d[1]);
    n_vec++; if ({lvl, o_sop, rdata} !== {15'd1, 1'b1, d[0]}) begin n_err++; $display("FAIL ct_both1 got lvl=%0d sop=%b %h exp 1 1 %h", lvl, o_sop, rdata, d[0]); end
    deq = 1; put(0, 0, 0, 0, d[2]);
    n_vec++; if ({lvl, rdata} !== {15'd1, d[1]}) begin n_err++; $display("FAIL ct_both2 got lvl=%0d %h exp 1 %h", lvl, rdata, d[1]); end
    idle_in(); deq = 1; cyc(); deq = 0;
    n_vec++; if ({lvl, empty, o_eop, rdata} !== {15'd0, 1'b1, 1'b1, d[2]}) begin n_err++; $display("FAIL ct_last got lvl=%0d empty=%b eop=%b %h exp 0 1 1 %h", lvl, empty, o_eop, rdata, d[2]); end
  endtask

  task automatic test_soft_reset();
    hard_reset(); ead = 0;
    put(1, 0, 1, 2, $urandom); put(0, 1, 0, 0, $urandom); idle_in();
    deq = 1; cyc(); deq = 0;
    sw_rstn = 0; cyc(); sw_rstn = 1;
    n_vec++; if ({lvl, empty, aempty, o_sop, rdata} !== {15'd0, 2'b11, 1'b0, 32'd0}) begin n_err++; $display("FAIL soft_reset got lvl=%0d empty=%b ae=%b sop=%b %h exp 0 1 1 0 0", lvl, empty, aempty, o_sop, rdata); end
  endtask

  task automatic test_fill();
    int n;
    hard_reset(); ead = 0; afv = 5'd2;
    for (int p = 0; p < 5; p++) begin
      n = (p < 4) ? 4095 : 4;
      for (int i = 0; i < n; i++) begin
        put(i == 0, 0, i == 0, n, $urandom);
        if (p == 4 && i < 2) begin
          n_vec++; if (afull !== (i == 1)) begin n_err++; $display("FAIL afull_at_%0d got %b exp %b", lvl, afull, i == 1); end
        end
      end
    end
    idle_in();
    n_vec++; if ({full, lvl} !== {1'b1, 15'd16384}) begin n_err++; $display("FAIL fill_full got full=%b lvl=%0d exp 1 16384", full, lvl); end
    put(0, 0, 0, 0, $urandom); idle_in();
    n_vec++; if ({ovf, full, lvl} !== {2'b11, 15'd16384}) begin n_err++; $display("FAIL overflow got ovf=%b full=%b lvl=%0d exp 1 1 16384", ovf, full, lvl); end
    deq = 1; repeat (10) cyc(); deq = 0;
    n_vec++; if ({o_sop, o_eop, rdata} !== e_rd) begin n_err++; $display("FAIL fill_read got %b%b %h exp %h", o_sop, o_eop, rdata, e_rd); end
    put(1, 0, 1, 20, $urandom); idle_in();
    n_vec++; if ({drop, lvl} !== {1'b1, 15'd16374}) begin n_err++; $display("FAIL drop_nospace got drop=%b lvl=%0d exp 1 16374", drop, lvl); end
  endtask

  task automatic test_random();
    int rem;
    logic [55:0] act, expv;
    for (int ph = 0; ph < 2; ph++) begin
      hard_reset(); ead = ph[0];
      afv = 5'($urandom); aev = 5'($urandom);
      rem = 0;
      for (int c = 0; c < 1500; c++) begin
        idle_in();
        enq = $urandom_range(0, 1) == 1;
        if (enq) begin
          if (rem == 0 || $urandom_range(0, 31) == 0) begin
            sop = 1; len = 12'($urandom_range(0, 9)); lenv = $urandom_range(0, 15) != 0; rem = int'(len);
          end else lenv = $urandom_range(0, 1) == 1;
          eop = $urandom_range(0, 15) == 0;
          wdata = $urandom;
          if (rem > 0) rem--;
        end
        deq = $urandom_range(0, 99) < 45;
        sw_rstn = $urandom_range(0, 399) != 0;
        cyc();
        sw_rstn = 1;
        act = {o_sop, o_eop, rdata, full, empty, afull, aempty, ovf, udf, drop, lvl};
        expv = exp_bus();
        n_vec++; if (act !== expv) begin n_err++; $display("FAIL random_ph%0d_cyc%0d got %h exp %h", ph, c, act, expv); end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_sf_packet();
    test_underflow();
    test_drops();
    test_cut_through();
    test_soft_reset();
    test_fill();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
